rv_mem_subsys: RTL

//   Synthesisable unified instruction/data memory for the STRV32I core; replaces the ad-hoc bench arrays.
//   Two ports share one word array: port I is a read-only fetch port, port D is a read/write port with byte masks.

---
 rtl/rv_mem_subsys.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rv_mem_subsys.sv
// rv_mem_subsys: unified fetch/data word memory with per-port wait states, one-outstanding handshake
// and error flagging for misaligned or out-of-range addresses.
module rv_mem_port #(
  parameter int WAIT_CYC = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic [31:0] rsp_data_in,
  input  logic        rsp_err_in,
  output logic        accept_out,
  output logic        busy_out,
  output logic        valid_out,
  output logic [31:0] rdata_out,
  output logic        err_out
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d, rdata_q, rdata_d;
  logic        herr_q, herr_d, err_q, err_d;
  assign accept_out = rst_in && req_in && (state_q != S_WAIT);
  assign busy_out   = (state_q == S_WAIT);
  assign valid_out  = (state_q == S_RESP);
  assign rdata_out  = rdata_q;
  assign err_out    = err_q;
  // Response is captured at accept and only moved to the outputs on entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    herr_d  = herr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = S_RESP;
        rdata_d = hold_q;
        err_d   = herr_q;
      end
    end else if (accept_out) begin
      hold_d  = rsp_data_in;
      herr_d  = rsp_err_in;
      state_d = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      cnt_d   = 3'(WAIT_CYC);
      if (WAIT_CYC == 0) begin
        rdata_d = rsp_data_in;
        err_d   = rsp_err_in;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      herr_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      herr_q  <= herr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

module rv_mem_subsys #(
  parameter int DEPTH_WORDS = 64,
  parameter int IM_WAIT     = 0,
  parameter int DM_WAIT     = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        im_req_in,
  input  logic [31:0] im_addr_in,
  output logic        im_busy_out,
  output logic        im_valid_out,
  output logic [31:0] im_rdata_out,
  output logic        im_err_out,
  input  logic        dm_req_in,
  input  logic        dm_wr_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  input  logic [3:0]  dm_mask_in,
  output logic        dm_busy_out,
  output logic        dm_valid_out,
  output logic [31:0] dm_rdata_out,
  output logic        dm_err_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] i_idx, d_idx;
  logic          i_err, d_err, i_acc, d_acc;
  logic [31:0]   i_rsp, d_rsp;
  assign i_idx = im_addr_in[AW+1:2];
  assign d_idx = dm_addr_in[AW+1:2];
  assign i_err = (|im_addr_in[1:0]) | (|im_addr_in[31:AW+2]);
  assign d_err = (|dm_addr_in[1:0]) | (|dm_addr_in[31:AW+2]);
  // Reads see the array before this edge's write lands, so a same-edge fetch returns the old word.
  assign i_rsp = i_err ? '0 : mem_q[i_idx];
  assign d_rsp = (d_err | dm_wr_in) ? '0 : mem_q[d_idx];
  rv_mem_port #(.WAIT_CYC(IM_WAIT)) u_im (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(im_req_in),
    .rsp_data_in(i_rsp), .rsp_err_in(i_err), .accept_out(i_acc),
    .busy_out(im_busy_out), .valid_out(im_valid_out),
    .rdata_out(im_rdata_out), .err_out(im_err_out)
  );
  rv_mem_port #(.WAIT_CYC(DM_WAIT)) u_dm (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(dm_req_in),
    .rsp_data_in(d_rsp), .rsp_err_in(d_err), .accept_out(d_acc),
    .busy_out(dm_busy_out), .valid_out(dm_valid_out),
    .rdata_out(dm_rdata_out), .err_out(dm_err_out)
  );
  always_ff @(posedge clk_in) begin
    if (d_acc && dm_wr_in && !d_err)
      for (int b = 0; b < 4; b++)
        if (dm_mask_in[b]) mem_q[d_idx][8*b +: 8] <= dm_wdata_in[8*b +: 8];
  end
endmodule
